sound_ch4_regs: RTL and testbench



---
 rtl/sound_ch4_regs_if.sv | 12 +
 rtl/sound_ch4_regs.sv | 128 ++++++++++++
 tb/tb_sound_ch4_regs.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/sound_ch4_regs_if.sv
// rtl/sound_ch4_regs_if.sv - CPU bus bundle for the channel 4 register front end
interface sound_ch4_regs_if;
  logic [15:0] iAddr;
  logic [7:0]  iData;
  logic        iWe;
  logic        iRe;
  logic [7:0]  oData;
  logic        oSelect;

  modport master (output iAddr, iData, iWe, iRe, input oData, oSelect);
  modport slave  (input iAddr, iData, iWe, iRe, output oData, oSelect);
endinterface

// File: rtl/sound_ch4_regs.sv
// rtl/sound_ch4_regs.sv - NR41-NR44 register front end for the noise channel
// Read-back masking is built only when SOUND_CH4_READBACK_EN is defined.
module sound_ch4_regs #(
  parameter int          TRIG_CYCLES = 4,
  parameter logic [15:0] BASE_ADDR   = 16'hFF20
) (
  input  logic             iClock,
  input  logic             iReset,
  sound_ch4_regs_if.slave  bus,
  input  logic             iPowerOn,
  input  logic             iLengthComplete,
  output logic [7:0]       oNR41,
  output logic [7:0]       oNR42,
  output logic [7:0]       oNR43,
  output logic [7:0]       oNR44,
  output logic             oOn
);

  localparam logic [0:0] ST_OFF = 1'b0;
  localparam logic [0:0] ST_ON  = 1'b1;
  localparam logic [3:0] TRIG_LOAD = 4'(TRIG_CYCLES);

  logic [7:0]  r_nr41;
  logic [7:0]  r_nr42;
  logic [7:0]  r_nr43;
  logic        r_nr44_b6;
  logic [3:0]  r_trig_cnt;
  logic [0:0]  r_state;
  logic        r_we_prev;
  logic        r_len_prev;

  logic [15:0] w_off;
  logic        w_hit;
  logic        w_accept;
  logic        w_trig;
  logic        w_dac;
  logic        w_dac_kill;
  logic        w_len_rise;

  // Offset compare keeps the hit window correct without a 17-bit upper bound.
  assign w_off      = bus.iAddr - BASE_ADDR;
  assign w_hit      = (w_off[15:2] == 14'd0);
  assign w_accept   = bus.iWe & ~r_we_prev & w_hit & iPowerOn;
  assign w_trig     = w_accept & (w_off[1:0] == 2'd3) & bus.iData[7];
  assign w_dac      = (r_nr42[7:3] != 5'd0);
  assign w_dac_kill = w_accept & (w_off[1:0] == 2'd1) & (bus.iData[7:3] == 5'd0);
  assign w_len_rise = iLengthComplete & ~r_len_prev;

  always_ff @(posedge iClock) begin
    if (iReset) begin
      r_we_prev  <= 1'b0;
      r_len_prev <= 1'b0;
    end else begin
      r_we_prev  <= bus.iWe;
      r_len_prev <= iLengthComplete;
    end
  end

  always_ff @(posedge iClock) begin
    if (iReset || !iPowerOn) begin
      r_nr41     <= 8'h00;
      r_nr42     <= 8'h00;
      r_nr43     <= 8'h00;
      r_nr44_b6  <= 1'b0;
      r_trig_cnt <= 4'd0;
    end else begin
      if (w_trig)
        r_trig_cnt <= TRIG_LOAD;
      else if (r_trig_cnt != 4'd0)
        r_trig_cnt <= r_trig_cnt - 4'd1;
      if (w_accept) begin
        case (w_off[1:0])
          2'd0:    r_nr41    <= bus.iData;
          2'd1:    r_nr42    <= bus.iData;
          2'd2:    r_nr43    <= bus.iData;
          default: r_nr44_b6 <= bus.iData[6];
        endcase
      end
    end
  end

  // A trigger with the DAC on outranks a same-cycle length expiry.
  always_ff @(posedge iClock) begin
    if (iReset || !iPowerOn) begin
      r_state <= ST_OFF;
    end else begin
      case (r_state)
        ST_OFF: if (w_trig && w_dac) r_state <= ST_ON;
        ST_ON:  if (!(w_trig && w_dac) && (w_len_rise || w_dac_kill)) r_state <= ST_OFF;
        default: r_state <= ST_OFF;
      endcase
    end
  end

`ifdef SOUND_CH4_READBACK_EN
  logic [7:0] w_rd_mux;
  always_comb begin
    w_rd_mux = 8'hFF;
    case (w_off[1:0])
      2'd0:    w_rd_mux = 8'hFF;
      2'd1:    w_rd_mux = r_nr42;
      2'd2:    w_rd_mux = r_nr43;
      default: w_rd_mux = {1'b1, r_nr44_b6, 6'h3F};
    endcase
  end
`endif

  always_ff @(posedge iClock) begin
    if (iReset) begin
      bus.oSelect <= 1'b0;
      bus.oData   <= 8'hFF;
    end else begin
      bus.oSelect <= bus.iRe & w_hit;
`ifdef SOUND_CH4_READBACK_EN
      bus.oData   <= (bus.iRe && w_hit) ? w_rd_mux : 8'hFF;
`else
      bus.oData   <= 8'hFF;
`endif
    end
  end

  assign oNR41 = r_nr41;
  assign oNR42 = r_nr42;
  assign oNR43 = r_nr43;
  assign oNR44 = {(r_trig_cnt != 4'd0), r_nr44_b6, 6'b000000};
  assign oOn   = (r_state == ST_ON);

endmodule

// File: tb/tb_sound_ch4_regs.sv
// tb/tb_sound_ch4_regs.sv - directed and random checks of sound_ch4_regs against a timestamp model
module tb_sound_ch4_regs;
  localparam int TRIG = 4;

  logic       iClock = 1'b0;
  logic       iReset;
  logic       iPowerOn;
  logic       iLengthComplete;
  logic [7:0] oNR41, oNR42, oNR43, oNR44;
  logic       oOn;

  sound_ch4_regs_if bus();

  sound_ch4_regs #(.TRIG_CYCLES(TRIG), .BASE_ADDR(16'hFF20)) dut (
    .iClock(iClock), .iReset(iReset), .bus(bus), .iPowerOn(iPowerOn),
    .iLengthComplete(iLengthComplete), .oNR41(oNR41), .oNR42(oNR42),
    .oNR43(oNR43), .oNR44(oNR44), .oOn(oOn)
  );

  always #5 iClock = ~iClock;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int pulse_hi = 0;

  logic [7:0] m_nr41, m_nr42, m_nr43;
  logic       m_b6, m_on, m_prev_we, m_prev_len, m_sel;
  logic [7:0] m_rd;
  int         m_last_trig;

  function automatic logic [7:0] rd_model(input int off);
`ifdef SOUND_CH4_READBACK_EN
    case (off)
      1: return m_nr42;
      2: return m_nr43;
      3: return {1'b1, m_b6, 6'h3F};
      default: return 8'hFF;
    endcase
`else
    return (off >= 0) ? 8'hFF : 8'hFF;
`endif
  endfunction

  task automatic model_step();
    int  off;
    bit  hit, acc;
    cyc++;
    off = int'(bus.iAddr) - 'hFF20;
    hit = (off >= 0 && off <= 3);
    if (iReset) begin
      m_nr41 = 0; m_nr42 = 0; m_nr43 = 0; m_b6 = 0; m_on = 0;
      m_last_trig = -1000; m_rd = 8'hFF; m_sel = 0; m_prev_we = 0; m_prev_len = 0;
      return;
    end
    m_sel = bus.iRe && hit;
    m_rd  = m_sel ? rd_model(off) : 8'hFF;
    acc = bus.iWe && !m_prev_we && hit && iPowerOn;
    if (!iPowerOn) begin
      m_nr41 = 0; m_nr42 = 0; m_nr43 = 0; m_b6 = 0; m_on = 0; m_last_trig = -1000;
    end else begin
      if (acc && off == 3 && bus.iData[7] && m_nr42[7:3] != 0)
        m_on = 1;
      else if ((iLengthComplete && !m_prev_len) || (acc && off == 1 && bus.iData < 8))
        m_on = 0;
      if (acc) begin
        case (off)
          0: m_nr41 = bus.iData;
          1: m_nr42 = bus.iData;
          2: m_nr43 = bus.iData;
          default: begin
            m_b6 = bus.iData[6];
            if (bus.iData[7]) m_last_trig = cyc;
          end
        endcase
      end
    end
    m_prev_we  = bus.iWe;
    m_prev_len = iLengthComplete;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
  endtask

  task automatic tick();
    logic pulse;
    @(posedge iClock);
    model_step();
    @(negedge iClock);
    pulse = (cyc - m_last_trig) < TRIG;
    if (oNR44[7]) pulse_hi++;
    check("nr41", oNR41, m_nr41);
    check("nr42", oNR42, m_nr42);
    check("nr43", oNR43, m_nr43);
    check("nr44", oNR44, {pulse, m_b6, 6'b0});
    check("on", {7'b0, oOn}, {7'b0, m_on});
    check("rdata", bus.oData, m_rd);
    check("select", {7'b0, bus.oSelect}, {7'b0, m_sel});
  endtask

  task automatic wr1(input logic [15:0] a, input logic [7:0] d);
    bus.iAddr = a; bus.iData = d; bus.iWe = 1'b1;
    tick();
    bus.iWe = 1'b0;
  endtask

  task automatic rd1(input logic [15:0] a);
    bus.iAddr = a; bus.iRe = 1'b1;
    tick();
    bus.iRe = 1'b0;
  endtask

  initial begin
    iReset = 1'b1; iPowerOn = 1'b0; iLengthComplete = 1'b0;
    bus.iAddr = 16'h0000; bus.iData = 8'h00; bus.iWe = 1'b0; bus.iRe = 1'b0;
    tick(); tick();
    check("rst_data", bus.oData, 8'hFF);
    check("rst_nr44", oNR44, 8'h00);
    iReset = 1'b0; iPowerOn = 1'b1;
    tick();

    // 1: long strobe, data changes mid-hold, single accept
    bus.iAddr = 16'hFF21; bus.iData = 8'hF3; bus.iWe = 1'b1;
    tick();
    check("t1_nr42", oNR42, 8'hF3);
    bus.iData = 8'h11;
    repeat (4) tick();
    bus.iWe = 1'b0; tick();
    check("t1_once", oNR42, 8'hF3);

    // 2: trigger with DAC on
    wr1(16'hFF21, 8'hF0); tick();
    wr1(16'hFF23, 8'hC0);
    check("t2_p0", oNR44, 8'hC0);
    repeat (3) begin tick(); check("t2_p", oNR44, 8'hC0); end
    tick();
    check("t2_end", oNR44, 8'h40);
    check("t2_on", {7'b0, oOn}, 8'h01);

    // 3: retrigger extends pulse, then length expiry
    pulse_hi = 0;
    wr1(16'hFF23, 8'h80); tick();
    wr1(16'hFF23, 8'h80);
    repeat (8) tick();
    check("t3_width", 8'(pulse_hi), 8'd6);
    iLengthComplete = 1'b1; tick();
    check("t3_len_off", {7'b0, oOn}, 8'h00);
    iLengthComplete = 1'b0; tick();

    // 4: DAC off trigger, then DAC-kill while on
    wr1(16'hFF21, 8'h07); tick();
    wr1(16'hFF23, 8'h80);
    check("t4_pulse", {7'b0, oNR44[7]}, 8'h01);
    check("t4_off", {7'b0, oOn}, 8'h00);
    repeat (4) tick();
    wr1(16'hFF21, 8'hF0); tick();
    wr1(16'hFF23, 8'h80); tick();
    check("t4_on", {7'b0, oOn}, 8'h01);
    wr1(16'hFF21, 8'h00);
    check("t4_kill", {7'b0, oOn}, 8'h00);
    tick();

    // 5: reads
    wr1(16'hFF22, 8'h5A); tick();
    wr1(16'hFF23, 8'h40); tick();
    rd1(16'hFF20); check("t5_ff20", bus.oData, 8'hFF);
    rd1(16'hFF22);
`ifdef SOUND_CH4_READBACK_EN
    check("t5_ff22", bus.oData, 8'h5A);
`else
    check("t5_ff22", bus.oData, 8'hFF);
`endif
    rd1(16'hFF23); check("t5_ff23", bus.oData, 8'hFF);
    check("t5_sel", {7'b0, bus.oSelect}, 8'h01);
    rd1(16'hFF24); check("t5_miss", {7'b0, bus.oSelect}, 8'h00);

    // 6: power drop mid-pulse
    wr1(16'hFF21, 8'hF0); tick();
    wr1(16'hFF23, 8'hC0); tick();
    iPowerOn = 1'b0; tick();
    check("t6_nr44", oNR44, 8'h00);
    check("t6_nr42", oNR42, 8'h00);
    check("t6_on", {7'b0, oOn}, 8'h00);
    wr1(16'hFF22, 8'h77); tick();
    iPowerOn = 1'b1; tick();
    check("t6_ignored", oNR43, 8'h00);

    // Reset mid-pulse
    wr1(16'hFF21, 8'hF0); tick();
    wr1(16'hFF23, 8'h80);
    iReset = 1'b1; tick();
    check("rst_pulse", oNR44, 8'h00);
    iReset = 1'b0; tick();

    // Random phase
    for (int i = 0; i < 600; i++) begin
      if (bus.iWe) begin
        if ($urandom_range(2) == 0) bus.iWe = 1'b0;
      end else if ($urandom_range(2) == 0) begin
        bus.iWe = 1'b1;
        bus.iAddr = 16'hFF1E + 16'($urandom_range(7));
        bus.iData = 8'($urandom);
        if ($urandom_range(3) == 0) bus.iData[7:3] = 5'd0;
      end
      if (!bus.iWe) bus.iAddr = 16'hFF1E + 16'($urandom_range(7));
      bus.iRe = 1'($urandom);
      if ($urandom_range(9) == 0) iLengthComplete = ~iLengthComplete;
      iPowerOn = ($urandom_range(39) != 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
